ip_codma_bus_arb: RTL and testbench

//  Address-phase arbiter/scheduler for the single codma BUS_IF master port.

---
 rtl/ip_codma_arb_pkg.sv | 18 +
 rtl/ip_codma_arb_tag_fifo.sv | 55 +++++
 rtl/ip_codma_bus_arb.sv | 201 ++++++++++++++++++++
 tb/tb_ip_codma_bus_arb.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ip_codma_arb_pkg.sv
// Shared types for the codma bus address-phase arbiter.
// Arbiter states, requester indices and the owner-tag type.
package ip_codma_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_ADDR = 2'd1,
        ARB_FULL = 2'd2
    } arb_state_t;

    localparam int ARB_REQ_MAIN = 0;
    localparam int ARB_REQ_AP   = 1;
    localparam int ARB_REQ_DP   = 2;
    localparam int ARB_NUM_REQ  = 3;

    typedef logic [$clog2(ARB_NUM_REQ)-1:0] arb_tag_t;

endpackage

// File: rtl/ip_codma_arb_tag_fifo.sv
// In-order owner-tag FIFO for accepted, not yet completed bus transactions.
// Supports simultaneous push and pop; flush empties it in one cycle.
module ip_codma_arb_tag_fifo #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 2
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic                         push_i,
    input  logic [TAG_W-1:0]             tag_i,
    input  logic                         pop_i,
    input  logic                         flush_i,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic [TAG_W-1:0]             head_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [TAG_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_rd;
    logic [PTR_W-1:0] r_wr;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk_i) begin
        if (push_i) begin
            r_mem[r_wr] <= tag_i;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally
    always_ff @(posedge clk_i) begin
        if (reset_i || flush_i) begin
            r_rd  <= '0;
            r_wr  <= '0;
            r_cnt <= '0;
        end else begin
            if (push_i) begin
                r_wr <= r_wr + 1'b1;
            end
            if (pop_i) begin
                r_rd <= r_rd + 1'b1;
            end
            case ({push_i, pop_i})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    assign count_o = r_cnt;
    assign head_o  = r_mem[r_rd];

endmodule

// File: rtl/ip_codma_bus_arb.sv
// Address-phase arbiter for the codma bus master port, round-robin by default.
// Define CODMA_ARB_PRIO_EN to give requester 0 strict priority over the others.
module ip_codma_bus_arb
    import ip_codma_arb_pkg::*;
#(
    parameter int NUM_REQ         = ARB_NUM_REQ,
    parameter int ADDR_W          = 32,
    parameter int SIZE_W          = 4,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                                   clk_i,
    input  logic                                   reset_i,
    input  logic [NUM_REQ-1:0]                     req_i,
    input  logic [NUM_REQ*ADDR_W-1:0]              req_addr_i,
    input  logic [NUM_REQ*SIZE_W-1:0]              req_size_i,
    input  logic [NUM_REQ-1:0]                     req_read_i,
    input  logic [NUM_REQ-1:0]                     req_write_i,
    input  logic                                   abort_i,
    output logic [NUM_REQ-1:0]                     gnt_o,
    output logic [NUM_REQ-1:0]                     done_o,
    output logic [ADDR_W-1:0]                      bus_addr_o,
    output logic [SIZE_W-1:0]                      bus_size_o,
    output logic                                   bus_read_o,
    output logic                                   bus_write_o,
    input  logic                                   bus_accept_i,
    input  logic                                   bus_done_i,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding_o,
    output logic                                   err_o
);

    localparam int TAG_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);
    localparam logic [CNT_W-1:0] MAX_M1  = CNT_W'(MAX_OUTSTANDING - 1);

    typedef logic [TAG_W-1:0] tag_t;

    arb_state_t         r_state;
    arb_state_t         w_state_nxt;
    tag_t               r_owner;
    tag_t               r_rr_ptr;
    logic [ADDR_W-1:0]  r_addr;
    logic [SIZE_W-1:0]  r_size;
    logic               r_read;
    logic               r_write;
    logic               r_err;

    logic [TAG_W:0]     w_pick_res;
    logic               w_pick_vld;
    tag_t               w_pick;
    logic               w_rr_upd;
    logic               w_latch;
    logic               w_push;
    logic               w_pop;
    logic               w_flush;
    logic               w_err_set;
    logic [NUM_REQ-1:0] w_gnt;
    logic [NUM_REQ-1:0] w_done;
    logic [CNT_W-1:0]   w_cnt;
    tag_t               w_head;
    logic               w_in_addr;

    // First requester at or after ptr+1, wrapping; MSB flags a hit
    function automatic logic [TAG_W:0] f_rr_pick(
        input logic [NUM_REQ-1:0] req,
        input tag_t               ptr
    );
        logic [TAG_W:0] res;
        int             idx;
        res = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            idx = (int'(ptr) + i) % NUM_REQ;
            if (req[idx[TAG_W-1:0]]) begin
                res = {1'b1, idx[TAG_W-1:0]};
            end
        end
        return res;
    endfunction

`ifdef CODMA_ARB_PRIO_EN
    always_comb begin
        if (req_i[ARB_REQ_MAIN]) begin
            w_pick_res = {1'b1, tag_t'(ARB_REQ_MAIN)};
        end else begin
            w_pick_res = f_rr_pick(req_i, r_rr_ptr);
        end
    end
    assign w_rr_upd = (r_owner != tag_t'(ARB_REQ_MAIN));
`else
    assign w_pick_res = f_rr_pick(req_i, r_rr_ptr);
    assign w_rr_upd   = 1'b1;
`endif

    assign w_pick_vld = w_pick_res[TAG_W];
    assign w_pick     = w_pick_res[TAG_W-1:0];

    ip_codma_arb_tag_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .TAG_W (TAG_W)
    ) u_tag_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .push_i  (w_push),
        .tag_i   (r_owner),
        .pop_i   (w_pop),
        .flush_i (w_flush),
        .count_o (w_cnt),
        .head_o  (w_head)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_latch     = 1'b0;
        w_push      = 1'b0;
        w_pop       = 1'b0;
        w_flush     = 1'b0;
        w_err_set   = 1'b0;
        w_gnt       = '0;
        w_done      = '0;
        if (reset_i) begin
            w_state_nxt = ARB_IDLE;
        end else if (abort_i) begin
            w_state_nxt = ARB_IDLE;
            w_flush     = 1'b1;
        end else begin
            if (bus_done_i) begin
                if (w_cnt != '0) begin
                    w_pop          = 1'b1;
                    w_done[w_head] = 1'b1;
                end else begin
                    w_err_set = 1'b1;
                end
            end
            unique case (r_state)
                ARB_IDLE: begin
                    if (w_pick_vld && (w_cnt < MAX_CNT)) begin
                        w_latch     = 1'b1;
                        w_state_nxt = ARB_ADDR;
                    end
                end
                ARB_ADDR: begin
                    if (bus_accept_i) begin
                        w_gnt[r_owner] = 1'b1;
                        w_push         = 1'b1;
                        // a same-cycle pop keeps the count below the limit
                        if ((w_cnt == MAX_M1) && !w_pop) begin
                            w_state_nxt = ARB_FULL;
                        end else begin
                            w_state_nxt = ARB_IDLE;
                        end
                    end
                end
                ARB_FULL: begin
                    if (bus_done_i) begin
                        w_state_nxt = ARB_IDLE;
                    end
                end
                default: w_state_nxt = ARB_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state  <= ARB_IDLE;
            r_owner  <= '0;
            r_addr   <= '0;
            r_size   <= '0;
            r_read   <= 1'b0;
            r_write  <= 1'b0;
            r_rr_ptr <= tag_t'(NUM_REQ - 1);
            r_err    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_latch) begin
                r_owner <= w_pick;
                r_addr  <= req_addr_i[int'(w_pick)*ADDR_W +: ADDR_W];
                r_size  <= req_size_i[int'(w_pick)*SIZE_W +: SIZE_W];
                r_read  <= req_read_i[w_pick];
                r_write <= req_write_i[w_pick];
            end
            if (w_push && w_rr_upd) begin
                r_rr_ptr <= r_owner;
            end
            if (w_err_set) begin
                r_err <= 1'b1;
            end
        end
    end

    assign w_in_addr     = (r_state == ARB_ADDR);
    assign bus_addr_o    = w_in_addr ? r_addr : '0;
    assign bus_size_o    = w_in_addr ? r_size : '0;
    assign bus_read_o    = w_in_addr & r_read;
    assign bus_write_o   = w_in_addr & r_write;
    assign gnt_o         = w_gnt;
    assign done_o        = w_done;
    assign outstanding_o = w_cnt;
    assign err_o         = r_err;

endmodule

// File: tb/tb_ip_codma_bus_arb.sv
// Randomized bench for ip_codma_bus_arb against a queue-based transaction model.
// Honours CODMA_ARB_PRIO_EN when building the expected arbitration order.
module tb_ip_codma_bus_arb;

    localparam int N   = 3;
    localparam int AW  = 32;
    localparam int SW  = 4;
    localparam int MAX = 4;
    localparam int CW  = $clog2(MAX + 1);
`ifdef CODMA_ARB_PRIO_EN
    localparam bit PRIO = 1'b1;
`else
    localparam bit PRIO = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset_i;
    logic [N-1:0]    req_i;
    logic [N*AW-1:0] req_addr_i;
    logic [N*SW-1:0] req_size_i;
    logic [N-1:0]    req_read_i;
    logic [N-1:0]    req_write_i;
    logic            abort_i;
    logic [N-1:0]    gnt_o;
    logic [N-1:0]    done_o;
    logic [AW-1:0]   bus_addr_o;
    logic [SW-1:0]   bus_size_o;
    logic            bus_read_o;
    logic            bus_write_o;
    logic            bus_accept_i;
    logic            bus_done_i;
    logic [CW-1:0]   outstanding_o;
    logic            err_o;

    always #5 clk = ~clk;

    ip_codma_bus_arb #(
        .NUM_REQ(N), .ADDR_W(AW), .SIZE_W(SW), .MAX_OUTSTANDING(MAX)
    ) dut (
        .clk_i(clk), .reset_i(reset_i), .req_i(req_i),
        .req_addr_i(req_addr_i), .req_size_i(req_size_i),
        .req_read_i(req_read_i), .req_write_i(req_write_i),
        .abort_i(abort_i), .gnt_o(gnt_o), .done_o(done_o),
        .bus_addr_o(bus_addr_o), .bus_size_o(bus_size_o),
        .bus_read_o(bus_read_o), .bus_write_o(bus_write_o),
        .bus_accept_i(bus_accept_i), .bus_done_i(bus_done_i),
        .outstanding_o(outstanding_o), .err_o(err_o)
    );

    int total = 0;
    int bad   = 0;

    // requester side
    logic [N-1:0]  act;
    logic [N-1:0]  en_mask;
    logic [AW-1:0] ra  [N];
    logic [SW-1:0] rs  [N];
    logic          rrd [N];
    logic [N-1:0]  last_ge;
    logic [N-1:0]  last_ga;
    logic [N-1:0]  last_da;
    int            g_log [$];

    // reference model: one pending address phase plus in-order owner queue
    int            m_q [$];
    bit            m_pend;
    int            m_own;
    logic [AW-1:0] m_addr;
    logic [SW-1:0] m_size;
    bit            m_rd;
    bit            m_wr;
    int            m_rr;
    bit            m_err;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_pend = 1'b0;
        m_rr   = N - 1;
        m_err  = 1'b0;
    endtask

    function automatic int m_pick(input logic [N-1:0] r);
        if (PRIO && r[0]) return 0;
        for (int k = 1; k <= N; k++) begin
            int c;
            c = (m_rr + k) % N;
            if (r[c]) return c;
        end
        return -1;
    endfunction

    task automatic drive_reqs(input int rate);
        for (int i = 0; i < N; i++) begin
            if (last_ge[i]) act[i] = 1'b0;
            if (!act[i] && en_mask[i] && ($urandom_range(99) < rate)) begin
                act[i] = 1'b1;
                ra[i]  = $urandom;
                rs[i]  = SW'($urandom);
                rrd[i] = 1'($urandom_range(1));
            end
        end
    endtask

    // called at a negedge; leaves at the next negedge
    task automatic cycle(input bit rst, input bit ab, input bit acc,
                         input bit dn);
        logic [N-1:0] eg;
        logic [N-1:0] ed;
        int           cnt0;
        int           pk;
        reset_i      = rst;
        abort_i      = ab;
        bus_accept_i = acc;
        bus_done_i   = dn;
        for (int i = 0; i < N; i++) begin
            req_i[i]             = act[i];
            req_addr_i[i*AW+:AW] = ra[i];
            req_size_i[i*SW+:SW] = rs[i];
            req_read_i[i]        = rrd[i];
            req_write_i[i]       = ~rrd[i];
        end
        #1;
        eg = '0;
        ed = '0;
        if (!rst && !ab && m_pend && acc) eg[m_own] = 1'b1;
        if (!rst && !ab && dn && m_q.size() != 0) ed[m_q[0]] = 1'b1;
        check("gnt", gnt_o, eg);
        check("done", done_o, ed);
        check("addr", bus_addr_o, m_pend ? m_addr : '0);
        check("size", bus_size_o, m_pend ? m_size : '0);
        check("rd", bus_read_o, m_pend && m_rd);
        check("wr", bus_write_o, m_pend && m_wr);
        check("outst", outstanding_o, m_q.size());
        check("err", err_o, m_err);
        last_ge = eg;
        last_ga = gnt_o;
        last_da = done_o;
        for (int i = 0; i < N; i++) if (gnt_o[i]) g_log.push_back(i);
        if (rst) begin
            model_reset();
        end else if (ab) begin
            m_pend = 1'b0;
            m_q.delete();
        end else begin
            cnt0 = m_q.size();
            if (dn) begin
                if (cnt0 > 0) void'(m_q.pop_front());
                else m_err = 1'b1;
            end
            if (m_pend) begin
                if (acc) begin
                    m_q.push_back(m_own);
                    if (!(PRIO && m_own == 0)) m_rr = m_own;
                    m_pend = 1'b0;
                end
            end else if (act != '0 && cnt0 < MAX) begin
                pk     = m_pick(act);
                m_pend = 1'b1;
                m_own  = pk;
                m_addr = ra[pk];
                m_size = rs[pk];
                m_rd   = rrd[pk];
                m_wr   = ~rrd[pk];
            end
        end
        @(negedge clk);
    endtask

    task automatic reset_seq();
        act     = '0;
        last_ge = '0;
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        g_log.delete();
    endtask

    task automatic run(input int n, input int rate, input bit acc,
                       input bit dn_when_busy);
        for (int c = 0; c < n; c++) begin
            drive_reqs(rate);
            cycle(1'b0, 1'b0, acc, dn_when_busy && (m_q.size() != 0));
        end
    endtask

    initial begin
        int exp1 [4];
        int g;
        act = '0; en_mask = '0; last_ge = '0;
        for (int i = 0; i < N; i++) begin
            ra[i] = '0; rs[i] = '0; rrd[i] = 1'b0;
        end
        reset_i = 1'b1; abort_i = 1'b0; req_i = '0;
        req_addr_i = '0; req_size_i = '0;
        req_read_i = '0; req_write_i = '0;
        bus_accept_i = 1'b0; bus_done_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        model_reset();
        reset_seq();

        // all requesters held high: round-robin grant order
        en_mask = 3'b111;
        run(8, 100, 1'b1, 1'b1);
        if (PRIO) exp1 = '{0, 0, 0, 0};
        else      exp1 = '{0, 1, 2, 0};
        check("t1_ngnt", g_log.size(), 4);
        for (int i = 0; i < 4; i++) begin
            g = (g_log.size() > i) ? g_log[i] : -1;
            check("t1_order", g, exp1[i]);
        end

        // fill to the outstanding limit, then one completion
        reset_seq();
        en_mask = 3'b010;
        run(9, 100, 1'b1, 1'b0);
        check("t2_full", outstanding_o, 4);
        check("t2_rd", bus_read_o, 0);
        drive_reqs(100);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        check("t2_done", last_da, 3'b010);
        run(3, 100, 1'b1, 1'b0);

        // accept and completion in the same cycle at count 2
        reset_seq();
        en_mask = 3'b001;
        run(5, 100, 1'b1, 1'b0);
        drive_reqs(100);
        cycle(1'b0, 1'b0, 1'b1, 1'b1);
        check("t3_gnt", last_ga, 3'b001);
        check("t3_done", last_da, 3'b001);
        check("t3_cnt", outstanding_o, 2);

        // abort during an address phase with accept high
        reset_seq();
        en_mask = 3'b100;
        run(5, 100, 1'b1, 1'b0);
        drive_reqs(100);
        cycle(1'b0, 1'b1, 1'b1, 1'b0);
        check("t4_gnt", last_ga, 3'b000);
        check("t4_strb", {bus_read_o, bus_write_o}, 2'b00);
        check("t4_cnt", outstanding_o, 0);

        // completion with nothing outstanding
        reset_seq();
        en_mask = 3'b000;
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        check("t5_done", last_da, 3'b000);
        check("t5_err", err_o, 1);
        run(3, 0, 1'b0, 1'b0);
        check("t5_sticky", err_o, 1);
        reset_seq();
        check("t5_clr", err_o, 0);

        // requester 0 joins while 1 and 2 are pending
        reset_seq();
        en_mask = 3'b110;
        drive_reqs(100);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        drive_reqs(100);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        en_mask = 3'b111;
        drive_reqs(100);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        drive_reqs(100);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        g = (g_log.size() > 1) ? g_log[1] : -1;
        check("t6_first", (g_log.size() > 0) ? g_log[0] : -1, 1);
        check("t6_next", g, PRIO ? 0 : 2);

        // random traffic with aborts and occasional resets
        reset_seq();
        en_mask = 3'b111;
        for (int c = 0; c < 3000; c++) begin
            bit rst;
            bit ab;
            bit acc;
            bit dn;
            drive_reqs(40);
            rst = ($urandom_range(199) == 0);
            ab  = ($urandom_range(49) == 0);
            acc = 1'($urandom_range(1));
            if (m_q.size() != 0) dn = ($urandom_range(99) < 35);
            else                 dn = ($urandom_range(99) == 0);
            cycle(rst, ab, acc, dn);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
